// File: rtl/nes_poll_scheduler.sv
module nes_poll_scheduler #(
  parameter int unsigned POLL_PERIOD  = 833333,
  parameter int unsigned TIMEOUT      = 50000,
  parameter int unsigned STABLE_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       bridge_ready,
  output logic       bridge_start,
  input  logic       bridge_valid,
  input  logic [7:0] bridge_joypad,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic       event_valid,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LOAD    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST    = TW'(1);
  localparam logic [3:0]    SC_MAX      = 4'(STABLE_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    START,
    WAIT_VALID,
    EVAL
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [PW-1:0] period_cnt;
  logic          poll_due;
  logic          wrap;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    sample;
  logic [7:0]    candidate;
  logic [3:0]    stable_cnt;

  logic [7:0]    cand_nx;
  logic [3:0]    cnt_nx;
  logic          publish;
  logic          timeout_hit;

  logic          pend_ev;
  logic [7:0]    pend_buttons;
  logic [7:0]    pend_pressed;
  logic [7:0]    pend_released;

  assign wrap = (period_cnt == PERIOD_LAST);

  always_comb begin
    state_nx    = state;
    cand_nx     = candidate;
    cnt_nx      = stable_cnt;
    publish     = 1'b0;
    timeout_hit = 1'b0;

    if (sample == candidate) begin
      cnt_nx = (stable_cnt < SC_MAX) ? stable_cnt + 4'd1 : SC_MAX;
    end else begin
      cand_nx = sample;
      cnt_nx  = 4'd1;
    end

    unique case (state)
      IDLE: begin
        if (enable && poll_due) state_nx = WAIT_READY;
      end
      WAIT_READY: begin
        if (!enable)          state_nx = IDLE;
        else if (bridge_ready) state_nx = START;
      end
      START: begin
        state_nx = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (bridge_valid) begin
          state_nx = EVAL;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end
      end
      EVAL: begin
        state_nx = IDLE;
        publish  = (cnt_nx == SC_MAX) && (cand_nx != buttons);
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bridge_start  <= 1'b0;
      period_cnt    <= '0;
      poll_due      <= 1'b0;
      tmo_cnt       <= '0;
      sample        <= '0;
      candidate     <= '0;
      stable_cnt    <= '0;
      pend_ev       <= 1'b0;
      pend_buttons  <= '0;
      pend_pressed  <= '0;
      pend_released <= '0;
      buttons       <= '0;
      pressed       <= '0;
      released      <= '0;
      event_valid   <= 1'b0;
      timeout_err   <= 1'b0;
      err_count     <= '0;
    end else begin
      state        <= state_nx;
      bridge_start <= (state_nx == START);

      if (!enable) begin
        period_cnt <= '0;
        poll_due   <= 1'b0;
      end else begin
        period_cnt <= wrap ? '0 : period_cnt + 1'b1;
        if (state == START)
          poll_due <= 1'b0;
        else if (wrap)
          poll_due <= 1'b1;
      end

      if (state == START)
        tmo_cnt <= TMO_LOAD;
      else if (state == WAIT_VALID && !bridge_valid && tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt - 1'b1;

      if (state == WAIT_VALID && bridge_valid)
        sample <= bridge_joypad;

      if (state == EVAL) begin
        candidate  <= cand_nx;
        stable_cnt <= cnt_nx;
      end

      // The EVAL decision is staged once so the published outputs land two
      // clocks after the edge that captured the sample.
      pend_ev <= publish;
      if (publish) begin
        pend_buttons  <= cand_nx;
        pend_pressed  <= cand_nx & ~buttons;
        pend_released <= ~cand_nx & buttons;
      end

      event_valid <= pend_ev;
      pressed     <= pend_ev ? pend_pressed  : '0;
      released    <= pend_ev ? pend_released : '0;
      if (pend_ev)
        buttons <= pend_buttons;

      timeout_err <= timeout_hit;
      if (timeout_hit && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
